// File: rtl/scie_fir_engine_pkg.sv
// Shared definitions for the SCIE FIR engine.
// Provides the command opcodes, the arithmetic mode encodings, the control FSM states
// and the accumulator width helper used by the engine top and its MAC datapath.
package scie_fir_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_COEF = 2'd0,
        OP_PUSH      = 2'd1,
        OP_COMPUTE   = 2'd2,
        OP_CLEAR     = 2'd3
    } cmd_op_e;

    // Mode 3 behaves like MODE_FIXED: bit 1 selects fixed-point formatting.
    localparam logic [1:0] MODE_UNSIGNED = 2'd0;
    localparam logic [1:0] MODE_SIGNED   = 2'd1;
    localparam logic [1:0] MODE_FIXED    = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StMac   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Wide enough for ORDER full-scale signed or unsigned products without overflow.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned idx_w);
        return 2 * data_w + idx_w + 1;
    endfunction

endpackage

// File: rtl/scie_fir_engine_if.sv
// Command/result bus between the core decoder (master) and the FIR engine (slave).
//   cmd_valid/cmd_ready : command handshake, cmd_op selects LOAD_COEF/PUSH/COMPUTE/CLEAR
//   cmd_data            : coefficient or sample value
//   cmd_index           : coefficient index for LOAD_COEF
//   cmd_mode            : arithmetic mode for COMPUTE
//   cmd_err             : one-cycle pulse on out-of-range coefficient index
//   res_valid/res_ready : result handshake, res_data carries the filter output
interface scie_fir_engine_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_index;
    logic [1:0]        cmd_mode;
    logic              cmd_err;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_index, cmd_mode, res_ready,
        input  cmd_ready, cmd_err, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_index, cmd_mode, res_ready,
        output cmd_ready, cmd_err, res_valid, res_data
    );

endinterface

// File: rtl/scie_fir_engine_mac.sv
// Second MAC stage and result formatter of the FIR engine.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the accumulator (start of a COMPUTE)
//   en           : accumulate coef * sample this cycle
//   mode         : 0 unsigned, 1 signed, 2/3 fixed-point with saturation
//   coef, sample : operands registered by the RAM read stage
//   result       : accumulator formatted to DATA_W bits (combinational)
module scie_fir_mac
    import scie_fir_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned FRAC   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] coef,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned ACC_W  = acc_w(DATA_W, IDX_W);
    localparam int unsigned PROD_W = 2 * DATA_W + 2;

    logic                     signed_ops;
    logic signed [DATA_W:0]   coef_ext;
    logic signed [DATA_W:0]   sample_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  shifted;
    logic [ACC_W-DATA_W-1:0]  hi;

    // One extra bit per operand lets a single signed multiplier serve both
    // zero-extended (unsigned) and sign-extended operands.
    always_comb begin
        signed_ops = (mode != MODE_UNSIGNED);
        coef_ext   = {signed_ops & coef[DATA_W-1], coef};
        sample_ext = {signed_ops & sample[DATA_W-1], sample};
        prod       = PROD_W'(coef_ext) * PROD_W'(sample_ext);
        prod_ext   = ACC_W'(prod);
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + prod_ext;
        end
    end

    // Fixed point: floor-shift by FRAC, then clamp when the bits above the result's
    // sign bit disagree with the accumulator sign.
    always_comb begin
        result  = '0;
        shifted = acc_q >>> FRAC;
        hi      = shifted[ACC_W-2:DATA_W-1];
        if (mode[1]) begin
            if (!shifted[ACC_W-1] && (|hi)) begin
                result = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (shifted[ACC_W-1] && !(&hi)) begin
                result = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                result = shifted[DATA_W-1:0];
            end
        end else begin
            result = acc_q[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/scie_fir_engine.sv
// Parametrised FIR multiply-accumulate engine for the SCIE custom-instruction path.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : command/result handshake bus (slave side)
//   busy         : high while a COMPUTE is in progress (MAC, DRAIN, DONE)
// Holds the coefficient and sample-history RAMs, the control FSM and the RAM read
// stage; the multiply/accumulate and result formatting live in scie_fir_mac.
module scie_fir_engine
    import scie_fir_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ORDER  = 200,
    parameter int unsigned FRAC   = 16,
    parameter int unsigned IDX_W  = $clog2(ORDER)
) (
    input  logic clock,
    input  logic reset,
    scie_fir_engine_if.slave bus,
    output logic busy
);

    localparam int unsigned       FILL_W   = $clog2(ORDER + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ORDER - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(ORDER);

    logic [DATA_W-1:0] coef_mem [ORDER];
    logic [DATA_W-1:0] hist_mem [ORDER];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [1:0]        mode_q, mode_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              cmd_err_q, cmd_err_d;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_coef_q;
    logic [DATA_W-1:0] s1_sample_q;

    logic              cmd_fire;
    logic              idx_ok;
    logic              coef_we;
    logic              hist_we;
    logic              acc_clear;
    logic              issue;
    logic              tap_live;
    logic [DATA_W-1:0] mac_result;

    assign cmd_fire = bus.cmd_valid && (state_q == StIdle);
    assign idx_ok   = (bus.cmd_index < DATA_W'(ORDER));
    // Taps beyond the number of pushed samples read stale RAM and must contribute 0.
    assign tap_live = (FILL_W'(k_q) < fill_q);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        mode_d      = mode_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        cmd_err_d   = 1'b0;
        coef_we     = 1'b0;
        hist_we     = 1'b0;
        acc_clear   = 1'b0;
        issue       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    unique case (cmd_op_e'(bus.cmd_op))
                        OP_LOAD_COEF: begin
                            coef_we   = idx_ok;
                            cmd_err_d = !idx_ok;
                        end
                        OP_PUSH: begin
                            hist_we  = 1'b1;
                            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
                            fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
                        end
                        OP_COMPUTE: begin
                            mode_d    = bus.cmd_mode;
                            acc_clear = 1'b1;
                            k_d       = '0;
                            // Newest sample sits just behind the write pointer.
                            rd_ptr_d  = (wr_ptr_q == '0) ? LAST_IDX : wr_ptr_q - 1'b1;
                            state_d   = StMac;
                        end
                        OP_CLEAR: begin
                            wr_ptr_d = '0;
                            fill_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            StMac: begin
                issue    = 1'b1;
                rd_ptr_d = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
                if (k_q == LAST_IDX) begin
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDrain: begin
                // First DRAIN cycle retires the last product; the second formats.
                if (!s1_valid_q) begin
                    res_valid_d = 1'b1;
                    res_data_d  = mac_result;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            mode_q      <= MODE_UNSIGNED;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            cmd_err_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            cmd_err_q   <= cmd_err_d;
            s1_valid_q  <= issue;
        end
    end

    // RAMs are not reset; fill tracks which history entries are meaningful.
    always_ff @(posedge clock) begin
        if (coef_we) begin
            coef_mem[bus.cmd_index[IDX_W-1:0]] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (hist_we) begin
            hist_mem[wr_ptr_q] <= bus.cmd_data;
        end
    end

    // MAC stage 1: RAM read.
    always_ff @(posedge clock) begin
        if (issue) begin
            s1_coef_q   <= coef_mem[k_q];
            s1_sample_q <= tap_live ? hist_mem[rd_ptr_q] : '0;
        end
    end

    scie_fir_mac #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .FRAC   (FRAC)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (acc_clear),
        .en     (s1_valid_q),
        .mode   (mode_q),
        .coef   (s1_coef_q),
        .sample (s1_sample_q),
        .result (mac_result)
    );

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.cmd_err   = cmd_err_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_scie_fir_engine.sv
// Self-checking bench for scie_fir_engine (ORDER=4, DATA_W=32, FRAC=16).
// Directed steps followed by a randomized command stream, all checked against a
// queue-based FIR reference model.
module tb_scie_fir_engine;
    import scie_fir_pkg::*;

    localparam int DATA_W = 32;
    localparam int ORDER  = 4;
    localparam int FRAC   = 16;
    localparam int ACC_W  = 2 * DATA_W + 2 + 1;

    logic clock;
    logic reset;
    logic busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] coef_m [ORDER];
    logic [31:0] hist_q [$];

    scie_fir_engine_if #(.DATA_W(DATA_W)) bus ();

    scie_fir_engine #(
        .DATA_W (DATA_W),
        .ORDER  (ORDER),
        .FRAC   (FRAC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // y = sum_k coef[k] * x[n-k] over the pushed samples, evaluated wide enough
    // that no intermediate overflows, then formatted by mode.
    function automatic logic [31:0] model_result(input logic [1:0] mode);
        logic signed [127:0] acc, a, b, sh;
        acc = '0;
        for (int k = 0; k < hist_q.size(); k++) begin
            if (mode == 2'd0) begin
                a = {96'b0, coef_m[k]};
                b = {96'b0, hist_q[k]};
            end else begin
                a = {{96{coef_m[k][31]}}, coef_m[k]};
                b = {{96{hist_q[k][31]}}, hist_q[k]};
            end
            acc = acc + a * b;
        end
        if (mode < 2'd2) return acc[31:0];
        sh = acc >>> FRAC;
        if (sh > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
        if (sh < -128'sh80000000) return 32'h80000000;
        return sh[31:0];
    endfunction

    function automatic logic [31:0] rand_val();
        if ($urandom_range(0, 1) == 1) return $urandom;
        return 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
    endfunction

    // Returns #1 after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] data,
                         input logic [31:0] idx, input logic [1:0] mode);
        int n;
        n = 0;
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_index = idx;
        bus.cmd_mode  = mode;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("cmd_accept_timeout", 32'(n), 32'd0);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        issue(OP_LOAD_COEF, data, 32'(idx), 2'd0);
        check("cmd_err_pulse", 32'(bus.cmd_err), 32'(idx >= ORDER));
        if (idx < ORDER) begin
            coef_m[idx] = data;
        end else begin
            @(posedge clock);
            #1;
            check("cmd_err_drop", 32'(bus.cmd_err), 32'd0);
        end
    endtask

    task automatic push(input logic [31:0] data);
        issue(OP_PUSH, data, 32'd0, 2'd0);
        hist_q.push_front(data);
        if (hist_q.size() > ORDER) void'(hist_q.pop_back());
    endtask

    task automatic clear_hist();
        issue(OP_CLEAR, 32'd0, 32'd0, 2'd0);
        hist_q.delete();
    endtask

    task automatic compute(input logic [1:0] mode, input string tag, input int hold);
        logic [31:0] exp;
        int cyc;
        exp = model_result(mode);
        issue(OP_COMPUTE, 32'd0, 32'd0, mode);
        check("busy_in_mac", 32'(busy), 32'd1);
        cyc = 0;
        while (!bus.res_valid && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(ORDER + 2));
        check(tag, bus.res_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
            check("hold_data", bus.res_data, exp);
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold_busy", 32'(busy), 32'd1);
        end
        bus.res_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.res_ready = 1'b0;
        check("res_valid_drop", 32'(bus.res_valid), 32'd0);
        check("back_to_idle", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = '0;
        bus.cmd_index = '0;
        bus.cmd_mode  = 2'd0;
        bus.res_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Unsigned basic filter with wrap-around of the history.
        for (int i = 0; i < ORDER; i++) load(i, 32'(i + 1));
        push(32'd10);
        compute(2'd0, "u_push10", 0);
        push(32'd20);
        compute(2'd0, "u_push20", 0);
        push(32'd30);
        push(32'd40);
        compute(2'd0, "u_push40", 0);
        push(32'd50);
        compute(2'd0, "u_wrap50", 10);

        // Out-of-range coefficient index leaves coefficients untouched.
        load(ORDER, 32'hDEADBEEF);
        compute(2'd0, "after_bad_load", 0);

        // Signed versus unsigned interpretation of the same operands.
        clear_hist();
        load(0, 32'hFFFFFFFF);
        for (int i = 1; i < ORDER; i++) load(i, 32'd0);
        push(32'd5);
        compute(2'd1, "signed_neg", 0);
        compute(2'd0, "unsigned_wrap", 0);
        check("acc_positive", 32'(dut.u_mac.acc_q[ACC_W-1]), 32'd0);

        // Fixed point and saturation.
        load(0, 32'h00008000);
        push(32'h00030000);
        compute(2'd2, "fixed_half", 0);
        load(0, 32'h7FFF0000);
        push(32'h7FFF0000);
        compute(2'd2, "fixed_sat_pos", 0);
        load(0, 32'h80000000);
        compute(2'd3, "fixed_sat_neg", 0);

        // Empty history yields zero.
        clear_hist();
        compute(2'd1, "empty_after_clear", 0);

        // Reset while the MAC is running.
        push(32'd7);
        push(32'd9);
        issue(OP_COMPUTE, 32'd0, 32'd0, 2'd0);
        @(posedge clock);
        #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        hist_q.delete();
        check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        compute(2'd0, "after_midrst", 0);

        // Randomized command stream.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                load($urandom_range(0, ORDER + 1), rand_val());
            end else if (r <= 6) begin
                push(rand_val());
            end else if (r == 7) begin
                clear_hist();
            end else begin
                compute(2'($urandom_range(0, 3)), "rand_compute", $urandom_range(0, 2));
            end
        end
        compute(2'd1, "final_signed", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
